// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI4 slave responder in front of a word-addressed internal memory.
//   Serves one transaction at a time (AW/W/B or AR/R), with no interleaving.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     AW*_S / AWVALID_S / AWREADY_S   write address channel
//     W*_S  / WVALID_S  / WREADY_S    write data channel
//     B*_S  / BVALID_S  / BREADY_S    write response channel
//     AR*_S / ARVALID_S / ARREADY_S   read address channel
//     R*_S  / RVALID_S  / RREADY_S    read data channel
//   The word index is addr[log2(DEPTH)+1:2]; upper address bits alias.
//   AxSIZE and AWLEN are not used; every beat is a full word and every
//   response is OKAY.
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDS_WIDTH  = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int DEPTH      = 16384
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IDS_WIDTH-1:0]    AWID_S,
  input  logic [ADDR_WIDTH-1:0]   AWADDR_S,
  input  logic [LEN_WIDTH-1:0]    AWLEN_S,
  input  logic [2:0]              AWSIZE_S,
  input  logic [1:0]              AWBURST_S,
  input  logic                    AWVALID_S,
  output logic                    AWREADY_S,
  input  logic [DATA_WIDTH-1:0]   WDATA_S,
  input  logic [DATA_WIDTH/8-1:0] WSTRB_S,
  input  logic                    WLAST_S,
  input  logic                    WVALID_S,
  output logic                    WREADY_S,
  output logic [IDS_WIDTH-1:0]    BID_S,
  output logic [1:0]              BRESP_S,
  output logic                    BVALID_S,
  input  logic                    BREADY_S,
  input  logic [IDS_WIDTH-1:0]    ARID_S,
  input  logic [ADDR_WIDTH-1:0]   ARADDR_S,
  input  logic [LEN_WIDTH-1:0]    ARLEN_S,
  input  logic [2:0]              ARSIZE_S,
  input  logic [1:0]              ARBURST_S,
  input  logic                    ARVALID_S,
  output logic                    ARREADY_S,
  output logic [IDS_WIDTH-1:0]    RID_S,
  output logic [DATA_WIDTH-1:0]   RDATA_S,
  output logic [1:0]              RRESP_S,
  output logic                    RLAST_S,
  output logic                    RVALID_S,
  input  logic                    RREADY_S
);
  localparam int STRB = DATA_WIDTH / 8;
  localparam int IW   = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

  state_t                r_state, w_next;
  logic                  r_prio_rd;     // 1: read wins the next AW/AR tie
  logic [IW-1:0]         r_waddr, r_raddr;
  logic                  r_wfixed, r_rfixed;
  logic [LEN_WIDTH-1:0]  r_len, r_beat;
  logic [IDS_WIDTH-1:0]  r_bid, r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          w_grant_w, w_grant_r;
  logic          w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic [IW-1:0] w_ar_idx, w_raddr_nxt;

  // Ignored inputs, kept so every port bit has a reader.
  logic w_unused;
  assign w_unused = ^{AWLEN_S, AWSIZE_S, ARSIZE_S, AWADDR_S, ARADDR_S};

  assign w_grant_w = AWVALID_S && (!ARVALID_S || !r_prio_rd);
  assign w_grant_r = ARVALID_S && (!AWVALID_S || r_prio_rd);

  assign w_aw_hs = AWVALID_S && AWREADY_S;
  assign w_w_hs  = WVALID_S  && WREADY_S;
  assign w_ar_hs = ARVALID_S && ARREADY_S;
  assign w_r_hs  = RVALID_S  && RREADY_S;

  assign w_ar_idx    = ARADDR_S[IW+1:2];
  assign w_raddr_nxt = r_rfixed ? r_raddr : r_raddr + 1'b1;  // wraps at DEPTH

  assign BID_S   = r_bid;
  assign RID_S   = r_rid;
  assign RDATA_S = r_rdata;
  assign BRESP_S = 2'b00;
  assign RRESP_S = 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    AWREADY_S = 1'b0;
    ARREADY_S = 1'b0;
    WREADY_S  = 1'b0;
    BVALID_S  = 1'b0;
    RVALID_S  = 1'b0;
    RLAST_S   = 1'b0;
    case (r_state)
      S_IDLE: begin
        AWREADY_S = w_grant_w;
        ARREADY_S = w_grant_r;
        if (w_grant_w)      w_next = S_WDATA;
        else if (w_grant_r) w_next = S_RDATA;
      end
      S_WDATA: begin
        WREADY_S = 1'b1;
        // WLAST alone terminates the burst; AWLEN is not consulted.
        if (WVALID_S && WLAST_S) w_next = S_WRESP;
      end
      S_WRESP: begin
        BVALID_S = 1'b1;
        if (BREADY_S) w_next = S_IDLE;
      end
      S_RDATA: begin
        RVALID_S = 1'b1;
        RLAST_S  = (r_beat == r_len);
        if (RREADY_S && (r_beat == r_len)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_rd <= 1'b1;
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_wfixed  <= 1'b0;
      r_rfixed  <= 1'b0;
      r_len     <= '0;
      r_beat    <= '0;
      r_bid     <= '0;
      r_rid     <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_bid     <= AWID_S;
        r_waddr   <= AWADDR_S[IW+1:2];
        r_wfixed  <= (AWBURST_S == 2'b00);
        r_prio_rd <= 1'b1;
      end
      if (w_w_hs && !r_wfixed) r_waddr <= r_waddr + 1'b1;
      if (w_ar_hs) begin
        r_rid     <= ARID_S;
        r_raddr   <= w_ar_idx;
        r_len     <= ARLEN_S;
        r_beat    <= '0;
        r_rfixed  <= (ARBURST_S == 2'b00);
        r_rdata   <= mem[w_ar_idx];
        r_prio_rd <= 1'b0;
      end
      // Prefetch the next beat on the accepting handshake so RDATA is
      // ready the following cycle; the last beat leaves RDATA as is.
      if (w_r_hs && !RLAST_S) begin
        r_raddr <= w_raddr_nxt;
        r_rdata <= mem[w_raddr_nxt];
        r_beat  <= r_beat + 1'b1;
      end
    end
  end

  // Memory array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < STRB; b++)
        if (WSTRB_S[b]) mem[r_waddr][8*b +: 8] <= WDATA_S[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Testbench for axi_sram_slave: directed scenarios plus randomized bursts,
// checked against a word-indexed associative-array memory model.
module tb_axi_sram_slave;
  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  AWID_S = '0, ARID_S = '0, BID_S, RID_S;
  logic [31:0] AWADDR_S = '0, ARADDR_S = '0, WDATA_S = '0, RDATA_S;
  logic [3:0]  AWLEN_S = '0, ARLEN_S = '0, WSTRB_S = '0;
  logic [2:0]  AWSIZE_S = 3'd2, ARSIZE_S = 3'd2;
  logic [1:0]  AWBURST_S = '0, ARBURST_S = '0, BRESP_S, RRESP_S;
  logic        AWVALID_S = 0, WLAST_S = 0, WVALID_S = 0, BREADY_S = 0;
  logic        ARVALID_S = 0, RREADY_S = 0;
  logic        AWREADY_S, WREADY_S, BVALID_S, ARREADY_S, RLAST_S, RVALID_S;

  axi_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
    .ARREADY_S(ARREADY_S), .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] mm [int];               // reference memory, keyed by word index
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          w_idx, r_idx, r_len;
  bit          w_fix, r_fix;
  logic [7:0]  w_id, r_id;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int a2i(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic int nidx(input int i, input bit fix);
    return fix ? i : (i + 1) % DEPTH;
  endfunction

  // Drive point for all tasks: 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic aw(input logic [7:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
    bit ok; int n = 0;
    AWID_S = id; AWADDR_S = addr; AWLEN_S = 4'(len); AWBURST_S = burst; AWVALID_S = 1;
    do begin @(negedge clk); ok = AWREADY_S; step(); n++; end while (!ok && n < 50);
    chk("aw_hs", ok, 1);
    AWVALID_S = 0;
    w_idx = a2i(addr); w_fix = (burst == 2'b00); w_id = id;
  endtask

  task automatic wbeats(input int nb, input bit gaps);
    bit ok; int n; logic [31:0] t;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin WVALID_S = 0; step(); end
      WDATA_S = wd[b]; WSTRB_S = ws[b]; WLAST_S = (b == nb - 1); WVALID_S = 1;
      n = 0;
      do begin @(negedge clk); ok = WREADY_S; step(); n++; end while (!ok && n < 50);
      chk("w_hs", ok, 1);
      t = mm.exists(w_idx) ? mm[w_idx] : 32'h0;
      for (int l = 0; l < 4; l++) if (ws[b][l]) t[8*l +: 8] = wd[b][8*l +: 8];
      mm[w_idx] = t;
      w_idx = nidx(w_idx, w_fix);
    end
    WVALID_S = 0; WLAST_S = 0;
    @(negedge clk);
    chk("b_latency", BVALID_S, 1);
    chk("b_id", BID_S, w_id);
    chk("b_resp", BRESP_S, 0);
    step();
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); chk("b_hold", {BVALID_S, BID_S}, {1'b1, w_id}); step();
    end
    BREADY_S = 1;
    @(negedge clk); chk("b_valid", BVALID_S, 1);
    step(); BREADY_S = 0;
    @(negedge clk); chk("b_drop", BVALID_S, 0);
    step();
  endtask

  task automatic ar(input logic [7:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
    bit ok; int n = 0;
    ARID_S = id; ARADDR_S = addr; ARLEN_S = 4'(len); ARBURST_S = burst; ARVALID_S = 1;
    do begin @(negedge clk); ok = ARREADY_S; step(); n++; end while (!ok && n < 50);
    chk("ar_hs", ok, 1);
    ARVALID_S = 0;
    r_idx = a2i(addr); r_fix = (burst == 2'b00); r_len = len; r_id = id;
  endtask

  // mode 0: RREADY always high; 1: toggles 1,0,1,0...; 2: random
  task automatic rbeats(input int mode);
    int b = 0, cyc = 0; bit rr;
    while (b <= r_len && cyc < 200) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      RREADY_S = rr;
      @(negedge clk);
      chk("r_valid", RVALID_S, 1);
      chk("r_data", RDATA_S, mm.exists(r_idx) ? mm[r_idx] : 32'hx);
      chk("r_id", RID_S, r_id);
      chk("r_last", RLAST_S, (b == r_len));
      chk("r_resp", RRESP_S, 0);
      step();
      if (rr) begin b++; r_idx = nidx(r_idx, r_fix); end
      cyc++;
    end
    chk("r_beats", b, r_len + 1);
    RREADY_S = 0;
    @(negedge clk);
    chk("r_drop", {RVALID_S, RLAST_S}, 2'b00);
    step();
  endtask

  always @(negedge clk) if (rst_n) chk("rdy_excl", AWREADY_S & ARREADY_S, 0);

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_aw", AWREADY_S, 0); chk("rst_w", WREADY_S, 0);
    chk("rst_b", BVALID_S, 0);   chk("rst_ar", ARREADY_S, 0);
    chk("rst_r", {RVALID_S, RLAST_S}, 0);
    chk("rst_ids", {BID_S, RID_S}, 0);
    chk("rst_data", {RDATA_S, BRESP_S, RRESP_S}, 0);
    step(); rst_n = 1; step();

    // single write then read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    aw(8'h12, 32'h40, 0, 2'b01); wbeats(1, 0);
    ar(8'h34, 32'h40, 0, 2'b01); rbeats(0);

    // INCR burst, read with RREADY toggling
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    aw(8'h01, 32'h100, 3, 2'b01); wbeats(4, 0);
    ar(8'h02, 32'h100, 3, 2'b01); rbeats(1);

    // byte strobes: expect 0x11BB33DD
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    aw(8'h03, 32'h200, 0, 2'b01); wbeats(1, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    aw(8'h04, 32'h200, 0, 2'b01); wbeats(1, 0);
    ar(8'h05, 32'h200, 0, 2'b01); rbeats(0);
    chk("strb_merge", RDATA_S, 32'h11BB33DD);

    // index wrap at DEPTH-1 and address aliasing above the index bits
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    aw(8'h06, 32'((DEPTH - 2) * 4), 3, 2'b01); wbeats(4, 0);
    ar(8'h07, 32'((DEPTH - 2) * 4 + DEPTH * 4), 3, 2'b01); rbeats(0);

    // FIXED burst write and read hold the address
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    aw(8'h08, 32'h300, 2, 2'b00); wbeats(3, 0);
    ar(8'h09, 32'h300, 2, 2'b00); rbeats(2);

    // randomized traffic in words 0..63
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      aw(8'($urandom), 32'(k * 64), 15, 2'b01); wbeats(16, 1);
    end
    for (int k = 0; k < 40; k++) begin
      int base = $urandom_range(0, 47), len = $urandom_range(0, 15);
      logic [1:0] bu = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        aw(8'($urandom), 32'(base * 4) | 32'($urandom_range(0, 3)), len, bu);
        wbeats(len + 1, 1);
      end else begin
        ar(8'($urandom), 32'(base * 4), len, bu); rbeats(2);
      end
    end

    // reset during the 2nd beat of a len=7 read
    ar(8'h0A, 32'h0, 7, 2'b01);
    RREADY_S = 1; step();
    #1 rst_n = 0; #1;
    chk("mid_rst_rv", {RVALID_S, RLAST_S}, 0);
    chk("mid_rst_other", {BVALID_S, AWREADY_S, ARREADY_S, WREADY_S}, 0);
    RREADY_S = 0;
    step(); rst_n = 1; step();
    ar(8'h0B, 32'h10, 2, 2'b01); rbeats(0);

    // AW/AR ties after a fresh reset: read first, then write
    rst_n = 0; step(); rst_n = 1; step();
    ARID_S = 8'h21; ARADDR_S = 32'h40; ARLEN_S = 0; ARBURST_S = 2'b01;
    AWID_S = 8'h22; AWADDR_S = 32'h80; AWLEN_S = 0; AWBURST_S = 2'b01;
    ARVALID_S = 1; AWVALID_S = 1;
    @(negedge clk);
    chk("tie1_ar", ARREADY_S, 1); chk("tie1_aw", AWREADY_S, 0);
    step(); ARVALID_S = 0; AWVALID_S = 0;
    r_idx = a2i(32'h40); r_fix = 0; r_len = 0; r_id = 8'h21;
    rbeats(0);
    ARVALID_S = 1; AWVALID_S = 1;
    @(negedge clk);
    chk("tie2_aw", AWREADY_S, 1); chk("tie2_ar", ARREADY_S, 0);
    step(); ARVALID_S = 0; AWVALID_S = 0;
    w_idx = a2i(32'h80); w_fix = 0; w_id = 8'h22;
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    wbeats(1, 0);
    ar(8'h23, 32'h80, 0, 2'b01); rbeats(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
